// File: rtl/program_counter_if.sv
// Fetch-address bus between the control path and the program counter.
// Stack control and status signals exist only when PC_CALL_STACK_EN is defined.
interface program_counter_if #(
  parameter int unsigned WIDTH = 15
);
  logic [WIDTH-1:0] in1;
  logic             re;
  logic             inc;
  logic [WIDTH-1:0] out1;
  logic             wrap;
`ifdef PC_CALL_STACK_EN
  logic             call;
  logic             ret;
  logic             stk_full;
  logic             stk_empty;
`endif

`ifdef PC_CALL_STACK_EN
  modport master (
    output in1, re, inc, call, ret,
    input  out1, wrap, stk_full, stk_empty
  );
  modport slave (
    input  in1, re, inc, call, ret,
    output out1, wrap, stk_full, stk_empty
  );
`else
  modport master (
    output in1, re, inc,
    input  out1, wrap
  );
  modport slave (
    input  in1, re, inc,
    output out1, wrap
  );
`endif
endinterface

// File: rtl/program_counter.sv
// Fetch-stage instruction-address register: reset, absolute load, increment or hold.
// Optional return-address stack (call/ret) compiled in when PC_CALL_STACK_EN is defined.
// Priority per edge: rst, ret, call, re, inc, hold.
module program_counter #(
  parameter int unsigned      WIDTH        = 15,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      STACK_DEPTH  = 4
) (
  input logic               clk,
  input logic               rst,
  program_counter_if.slave  bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] pc_plus1;

  assign pc_plus1 = pc_q + WIDTH'(1);

`ifdef PC_CALL_STACK_EN
  localparam int unsigned PtrW = $clog2(STACK_DEPTH);
  localparam logic [PtrW:0] Depth = (PtrW + 1)'(STACK_DEPTH);

  // sp_q counts occupied entries (0..STACK_DEPTH); top of stack is at sp_q-1.
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PtrW:0]    sp_q, sp_d;
  logic [PtrW-1:0]  top_idx;
  logic             push, stk_full, stk_empty;

  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == Depth);
  assign top_idx   = sp_q[PtrW-1:0] - PtrW'(1);
`endif

  // Next-state selection in priority order.
  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
`ifdef PC_CALL_STACK_EN
    sp_d = sp_q;
    push = 1'b0;
    if (bus.ret) begin
      // Return on empty stack leaves everything unchanged.
      if (!stk_empty) begin
        pc_d = stack_q[top_idx];
        sp_d = sp_q - (PtrW + 1)'(1);
      end
    end else if (bus.call) begin
      pc_d = bus.in1;
      // A full stack drops the return address but still takes the jump.
      if (!stk_full) begin
        push = 1'b1;
        sp_d = sp_q + (PtrW + 1)'(1);
      end
    end else
`endif
    if (bus.re) begin
      pc_d = bus.in1;
    end else if (bus.inc) begin
      pc_d   = pc_plus1;
      wrap_d = &pc_q;
    end
  end

  // PC and wrap flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_VECTOR;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef PC_CALL_STACK_EN
  // Stack pointer; storage itself needs no reset since sp_q gates all reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Return-address storage written at the current free slot.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_q[sp_q[PtrW-1:0]] <= pc_plus1;
    end
  end

  assign bus.stk_full  = stk_full;
  assign bus.stk_empty = stk_empty;
`endif

  assign bus.out1 = pc_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter; stack cases run when PC_CALL_STACK_EN is defined.
module tb_program_counter;

  localparam int unsigned Width = 15;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  program_counter_if #(.WIDTH(Width)) bus ();

  program_counter #(
    .WIDTH       (Width),
    .RESET_VECTOR('0),
    .STACK_DEPTH (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    bus.in1 = '0;
    bus.re  = 1'b0;
    bus.inc = 1'b0;
`ifdef PC_CALL_STACK_EN
    bus.call = 1'b0;
    bus.ret  = 1'b0;
`endif
    #2;
    step();
    check_eq("reset_pc", 32'(bus.out1), 32'h0);
    check_eq("reset_wrap", 32'(bus.wrap), 32'h0);
`ifdef PC_CALL_STACK_EN
    check_eq("reset_empty", 32'(bus.stk_empty), 32'h1);
    check_eq("reset_full", 32'(bus.stk_full), 32'h0);
`endif
    bus.inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_over_inc", 32'(bus.out1), 32'h0);
    end
    rst     = 1'b0;
    bus.inc = 1'b0;

    // Load then hold.
    bus.in1 = 15'd5;
    bus.re  = 1'b1;
    step();
    check_eq("load5", 32'(bus.out1), 32'd5);
    bus.re = 1'b0;
    step();
    check_eq("hold5_a", 32'(bus.out1), 32'd5);
    step();
    check_eq("hold5_b", 32'(bus.out1), 32'd5);

    // Increment.
    bus.inc = 1'b1;
    step();
    check_eq("inc6", 32'(bus.out1), 32'd6);
    bus.inc = 1'b0;
    step();
    check_eq("hold6", 32'(bus.out1), 32'd6);
    bus.inc = 1'b1;
    repeat (3) step();
    check_eq("inc9", 32'(bus.out1), 32'd9);
    check_eq("inc9_wrap", 32'(bus.wrap), 32'h0);

    // Load beats increment.
    bus.re  = 1'b1;
    bus.in1 = 15'd100;
    step();
    check_eq("re_over_inc", 32'(bus.out1), 32'd100);

    // Wrap-around.
    bus.inc = 1'b0;
    bus.in1 = 15'h7fff;
    step();
    check_eq("load_max", 32'(bus.out1), 32'h7fff);
    check_eq("load_max_wrap", 32'(bus.wrap), 32'h0);
    bus.re  = 1'b0;
    bus.inc = 1'b1;
    step();
    check_eq("wrap_pc", 32'(bus.out1), 32'h0);
    check_eq("wrap_set", 32'(bus.wrap), 32'h1);
    step();
    check_eq("after_wrap_pc", 32'(bus.out1), 32'h1);
    check_eq("after_wrap_clr", 32'(bus.wrap), 32'h0);

    // Load of zero must not flag wrap.
    bus.inc = 1'b0;
    bus.re  = 1'b1;
    bus.in1 = 15'd0;
    step();
    check_eq("load0_pc", 32'(bus.out1), 32'h0);
    check_eq("load0_wrap", 32'(bus.wrap), 32'h0);

    // Reset mid-operation overrides a load.
    bus.in1 = 15'd20;
    step();
    check_eq("load20", 32'(bus.out1), 32'd20);
    rst     = 1'b1;
    bus.in1 = 15'd33;
    step();
    check_eq("rst_over_re", 32'(bus.out1), 32'h0);
    rst    = 1'b0;
    bus.re = 1'b0;

`ifdef PC_CALL_STACK_EN
    bus.re  = 1'b1;
    bus.in1 = 15'd10;
    step();
    bus.re   = 1'b0;
    bus.call = 1'b1;
    bus.in1  = 15'd50;
    step();
    check_eq("call50", 32'(bus.out1), 32'd50);
    check_eq("call50_empty", 32'(bus.stk_empty), 32'h0);
    bus.call = 1'b0;
    bus.ret  = 1'b1;
    step();
    check_eq("ret11", 32'(bus.out1), 32'd11);
    check_eq("ret11_empty", 32'(bus.stk_empty), 32'h1);
    step();
    check_eq("ret_empty_hold", 32'(bus.out1), 32'd11);
    bus.ret  = 1'b0;
    bus.call = 1'b1;
    // Pushes 12, 101, 201, 301; the fifth (401) is dropped.
    for (int i = 1; i <= 5; i++) begin
      bus.in1 = 15'(i * 100);
      step();
    end
    check_eq("call5_pc", 32'(bus.out1), 32'd500);
    check_eq("call5_full", 32'(bus.stk_full), 32'h1);
    bus.call = 1'b0;
    bus.ret  = 1'b1;
    step();
    check_eq("pop301", 32'(bus.out1), 32'd301);
    check_eq("pop301_full", 32'(bus.stk_full), 32'h0);
    bus.call = 1'b1;
    step();
    check_eq("ret_over_call", 32'(bus.out1), 32'd201);
    bus.call = 1'b0;
    step();
    check_eq("pop101", 32'(bus.out1), 32'd101);
    step();
    check_eq("pop12", 32'(bus.out1), 32'd12);
    check_eq("pop12_empty", 32'(bus.stk_empty), 32'h1);
    bus.ret = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
